// File: rtl/debounce_bank.sv
// debounce_bank: per-channel two-flop synchronizer plus debounce FSM with optional auto-repeat.
module debounce_bank #(
    parameter int N_CH   = 4,
    parameter int DELAY  = 74999999,
    parameter int REPEAT = 0,
    parameter int CNT_W  = $clog2((DELAY > REPEAT ? DELAY : REPEAT) + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] signal,
    output logic [N_CH-1:0] signal_established,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic            any_established
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DELAY - 1);
    localparam logic [CNT_W-1:0] R_LAST = CNT_W'(REPEAT > 0 ? REPEAT - 1 : 0);
    logic [N_CH-1:0] sync1, s;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= signal;
            s     <= sync1;
        end
    end
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t state, state_n;
        logic [CNT_W-1:0] cnt, cnt_n, rcnt, rcnt_n;
        logic est, pp, rp, press_n, release_n;
        always_ff @(posedge clk) begin
            if (reset) begin
                state <= IDLE;
                cnt   <= '0;
                rcnt  <= '0;
                est   <= 1'b0;
                pp    <= 1'b0;
                rp    <= 1'b0;
            end else begin
                state <= state_n;
                cnt   <= cnt_n;
                rcnt  <= rcnt_n;
                est   <= (state_n == HELD) || (state_n == RELEASE_WAIT);
                pp    <= press_n;
                rp    <= release_n;
            end
        end
        // The repeat counter only advances on held samples, so release glitches pause the cadence.
        always_comb begin
            state_n   = state;
            cnt_n     = cnt;
            rcnt_n    = rcnt;
            press_n   = 1'b0;
            release_n = 1'b0;
            case (state)
                IDLE: if (s[i]) begin
                    state_n = PRESS_WAIT;
                    cnt_n   = '0;
                end
                PRESS_WAIT: if (!s[i]) state_n = IDLE;
                    else if (cnt == D_LAST) begin
                        state_n = HELD;
                        press_n = 1'b1;
                        rcnt_n  = '0;
                    end else cnt_n = cnt + CNT_W'(1);
                HELD: if (!s[i]) begin
                        state_n = RELEASE_WAIT;
                        cnt_n   = '0;
                    end else if (REPEAT > 0) begin
                        press_n = rcnt == R_LAST;
                        rcnt_n  = rcnt == R_LAST ? '0 : rcnt + CNT_W'(1);
                    end
                RELEASE_WAIT: if (s[i]) state_n = HELD;
                    else if (cnt == D_LAST) begin
                        state_n   = IDLE;
                        release_n = 1'b1;
                    end else cnt_n = cnt + CNT_W'(1);
                default: state_n = IDLE;
            endcase
        end
        assign signal_established[i] = est;
        assign press_pulse[i]        = pp;
        assign release_pulse[i]      = rp;
    end
    assign any_established = |signal_established;
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: scoreboard bench comparing two debounce_bank configurations against a run-length model.
module tb_debounce_bank;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] sig_a = '0;
    logic [2:0] sig_b = '0;
    logic [1:0] est_a, pp_a, rp_a;
    logic [2:0] est_b, pp_b, rp_b;
    logic any_a, any_b;
    int total = 0;
    int bad = 0;
    int cyc_n = 0;

    localparam int DA = 4, RA = 6, DB = 1, RB = 0;

    always #5 clk = ~clk;

    debounce_bank #(.N_CH(2), .DELAY(DA), .REPEAT(RA)) dut_a (
        .clk(clk), .reset(reset), .signal(sig_a),
        .signal_established(est_a), .press_pulse(pp_a),
        .release_pulse(rp_a), .any_established(any_a)
    );
    debounce_bank #(.N_CH(3), .DELAY(DB), .REPEAT(RB)) dut_b (
        .clk(clk), .reset(reset), .signal(sig_b),
        .signal_established(est_b), .press_pulse(pp_b),
        .release_pulse(rp_b), .any_established(any_b)
    );

    typedef struct packed {
        logic [1:0] ea, pa, ra;
        logic       aa;
        logic [2:0] eb, pb, rb;
        logic       ab;
    } exp_t;
    exp_t q[$];

    // Model: a level is accepted once the synchronized sample has differed from it for DELAY+1 samples.
    bit m_p1[2][3], m_p2[2][3], m_est[2][3], m_pp[2][3], m_rp[2][3];
    int m_streak[2][3], m_ticks[2][3];

    task automatic step(input int u, input logic r, input logic [2:0] sig, input int nch, input int dly, input int rep);
        bit s;
        for (int c = 0; c < nch; c++) begin
            if (r) begin
                m_p1[u][c] = 0; m_p2[u][c] = 0; m_est[u][c] = 0;
                m_pp[u][c] = 0; m_rp[u][c] = 0; m_streak[u][c] = 0; m_ticks[u][c] = 0;
            end else begin
                s = m_p2[u][c];
                m_p2[u][c] = m_p1[u][c];
                m_p1[u][c] = sig[c];
                m_pp[u][c] = 0;
                m_rp[u][c] = 0;
                if (s != m_est[u][c]) begin
                    m_streak[u][c]++;
                    if (m_streak[u][c] == dly + 1) begin
                        m_est[u][c] = s;
                        m_streak[u][c] = 0;
                        if (s) begin
                            m_pp[u][c] = 1;
                            m_ticks[u][c] = 0;
                        end else m_rp[u][c] = 1;
                    end
                end else begin
                    if (m_streak[u][c] == 0 && m_est[u][c] && rep > 0) begin
                        m_ticks[u][c]++;
                        if (m_ticks[u][c] % rep == 0) m_pp[u][c] = 1;
                    end
                    m_streak[u][c] = 0;
                end
            end
        end
    endtask

    task automatic cyc(input logic r, input logic [1:0] a, input logic [2:0] b);
        exp_t e;
        @(negedge clk);
        reset = r;
        sig_a = a;
        sig_b = b;
        step(0, r, {1'b0, a}, 2, DA, RA);
        step(1, r, b, 3, DB, RB);
        for (int c = 0; c < 2; c++) begin
            e.ea[c] = m_est[0][c]; e.pa[c] = m_pp[0][c]; e.ra[c] = m_rp[0][c];
        end
        for (int c = 0; c < 3; c++) begin
            e.eb[c] = m_est[1][c]; e.pb[c] = m_pp[1][c]; e.rb[c] = m_rp[1][c];
        end
        e.aa = |e.ea;
        e.ab = |e.eb;
        q.push_back(e);
    endtask

    task automatic run(input logic r, input logic [1:0] a, input logic [2:0] b, input int n);
        for (int i = 0; i < n; i++) cyc(r, a, b);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%b want=%b", name, cyc_n, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cyc_n++;
                chk("est_a", {6'b0, est_a}, {6'b0, e.ea});
                chk("press_a", {6'b0, pp_a}, {6'b0, e.pa});
                chk("release_a", {6'b0, rp_a}, {6'b0, e.ra});
                chk("any_a", {7'b0, any_a}, {7'b0, e.aa});
                chk("est_b", {5'b0, est_b}, {5'b0, e.eb});
                chk("press_b", {5'b0, pp_b}, {5'b0, e.pb});
                chk("release_b", {5'b0, rp_b}, {5'b0, e.rb});
                chk("any_b", {7'b0, any_b}, {7'b0, e.ab});
            end
        end
    end

    initial begin
        logic [1:0] ra;
        logic [2:0] rb;
        run(1, 2'b00, 3'b000, 3);
        run(0, 2'b01, 3'b001, 12);
        run(0, 2'b00, 3'b000, 10);
        run(0, 2'b01, 3'b010, 3);
        run(0, 2'b00, 3'b000, 1);
        run(0, 2'b01, 3'b010, 12);
        run(0, 2'b01, 3'b010, 30);
        run(0, 2'b00, 3'b000, 2);
        run(0, 2'b01, 3'b010, 10);
        run(0, 2'b00, 3'b000, 10);
        run(0, 2'b01, 3'b100, 4);
        run(1, 2'b01, 3'b100, 1);
        run(0, 2'b01, 3'b100, 10);
        run(1, 2'b01, 3'b100, 1);
        run(0, 2'b01, 3'b100, 10);
        run(0, 2'b00, 3'b000, 10);
        run(0, 2'b11, 3'b111, 10);
        run(0, 2'b10, 3'b011, 8);
        run(0, 2'b00, 3'b000, 8);
        ra = '0;
        rb = '0;
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < 2; c++) if ($urandom_range(0, 5) == 0) ra[c] = ~ra[c];
            for (int c = 0; c < 3; c++) if ($urandom_range(0, 3) == 0) rb[c] = ~rb[c];
            cyc($urandom_range(0, 149) == 0, ra, rb);
        end
        run(0, 2'b00, 3'b000, 12);
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
